// File: rtl/instr_fetch_sequencer_pkg.sv
// Opcode map, flag index and FSM encoding shared by the fetch sequencer
// and the downstream ALU/register stage.
package instr_fetch_sequencer_pkg;

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_SUB  = 8'h01;
    localparam logic [7:0] OP_AND  = 8'h02;
    localparam logic [7:0] OP_OR   = 8'h03;
    localparam logic [7:0] OP_XOR  = 8'h04;
    localparam logic [7:0] OP_LD   = 8'h10;
    localparam logic [7:0] OP_ST   = 8'h12;
    localparam logic [7:0] OP_JMP  = 8'hF0;
    localparam logic [7:0] OP_JZ   = 8'hF1;
    localparam logic [7:0] OP_NOP  = 8'hFE;
    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam int FLAG_Z = 0;

    // Operator word driven downstream whenever nothing is being issued.
    localparam logic [15:0] NOP_OPERATOR = {OP_NOP, 8'h00};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Control-flow opcodes are consumed by the sequencer and never issued.
    function automatic logic is_flow_op(input logic [7:0] op);
        return (op == OP_JMP) || (op == OP_JZ) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer.sv
// Two-cycle FETCH/EXEC sequencer: reads a synchronous program ROM, resolves
// JMP/JZ/HALT locally and issues every other word to the ALU/register stage.
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic [3:0]        alu_flags,
    output logic [15:0]       operator,
    output logic [15:0]       operand,
    output logic              issue_valid,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output state_t            dbg_state_o
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Handshake: issue_valid is a one-cycle strobe with no back-pressure; the
    // downstream stage must accept operator/operand in every cycle it is high.

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       operator_q, operator_d;
    logic [15:0]       operand_q, operand_d;
    logic              issue_q, issue_d;

    logic [7:0]        opcode;
    logic [ADDR_W-1:0] jump_target;
    logic              zero_flag;
    logic              unused_flags;

    assign opcode       = rom_data[31:24];
    assign jump_target  = rom_data[ADDR_W-1:0];
    assign zero_flag    = alu_flags[FLAG_Z];
    assign unused_flags = ^alu_flags[3:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            count_q    <= '0;
            operator_q <= NOP_OPERATOR;
            operand_q  <= '0;
            issue_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            operator_q <= operator_d;
            operand_q  <= operand_d;
            issue_q    <= issue_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        operator_d = NOP_OPERATOR;
        operand_d  = '0;
        issue_d    = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = start_addr;
                    count_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_flow_op(opcode)) begin
                    case (opcode)
                        OP_JMP:  pc_d = jump_target;
                        OP_JZ:   pc_d = zero_flag ? jump_target : pc_q + PC_ONE;
                        default: state_d = S_HALT;
                    endcase
                end else begin
                    operator_d = rom_data[31:16];
                    operand_d  = rom_data[15:0];
                    issue_d    = 1'b1;
                    pc_d       = pc_q + PC_ONE;
                    count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The ROM registers its address internally, so pc drives it directly.
    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign instr_count = count_q;
    assign operator    = operator_q;
    assign operand     = operand_q;
    assign issue_valid = issue_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer: a table of single-instruction
// vectors plus hand-written multi-cycle sequences.
module tb_instr_fetch_sequencer;
    import instr_fetch_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic [3:0]  alu_flags;
    logic [15:0] operator;
    logic [15:0] operand;
    logic        issue_valid;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;
    logic [15:0] instr_count;
    state_t      dbg_state;

    logic [31:0] rom [256];
    logic [31:0] exp_q [$];

    int checks;
    int errors;

    instr_fetch_sequencer #(.ADDR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .alu_flags   (alu_flags),
        .operator    (operator),
        .operand     (operand),
        .issue_valid (issue_valid),
        .busy        (busy),
        .halted      (halted),
        .pc          (pc),
        .instr_count (instr_count),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program ROM model: data one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [7:0]  addr;
        logic [31:0] word;
        logic [3:0]  flags;
        logic        exp_issue;
        logic [15:0] exp_op;
        logic [15:0] exp_opnd;
        logic [7:0]  exp_pc;
        logic        exp_halt;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] addr);
        start      = 1'b1;
        start_addr = addr;
        tick();
        start      = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'h0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
        check({tag, "_operator"}, 32'(operator), 32'hFE00);
        check({tag, "_operand"}, 32'(operand), 32'h0);
        check({tag, "_issue"}, 32'(issue_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_halted"}, 32'(halted), 32'h0);
        check({tag, "_count"}, 32'(instr_count), 32'h0);
        check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    endtask

    initial begin
        int issues;
        int last_issue;
        int gap;
        bit done;
        logic [31:0] exp_word;

        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        alu_flags  = '0;
        for (int i = 0; i < 256; i++) rom[i] = 32'hFF00_0000;

        vecs[0] = '{"sub_at0",   8'h00, 32'h0101_0004, 4'b0000, 1'b1, 16'h0101, 16'h0004, 8'h01, 1'b0, 16'd1};
        vecs[1] = '{"xor_at5",   8'h05, 32'h0400_00AB, 4'b0000, 1'b1, 16'h0400, 16'h00AB, 8'h06, 1'b0, 16'd1};
        vecs[2] = '{"jmp0",      8'h03, 32'hF000_0000, 4'b0000, 1'b0, 16'hFE00, 16'h0000, 8'h00, 1'b0, 16'd0};
        vecs[3] = '{"jz_taken",  8'h07, 32'hF100_0010, 4'b0001, 1'b0, 16'hFE00, 16'h0000, 8'h10, 1'b0, 16'd0};
        vecs[4] = '{"jz_not",    8'h07, 32'hF100_0010, 4'b0000, 1'b0, 16'hFE00, 16'h0000, 8'h08, 1'b0, 16'd0};
        vecs[5] = '{"jz_hiflag", 8'h07, 32'hF100_0010, 4'b1110, 1'b0, 16'hFE00, 16'h0000, 8'h08, 1'b0, 16'd0};
        vecs[6] = '{"wrap_ff",   8'hFF, 32'h1200_0033, 4'b0000, 1'b1, 16'h1200, 16'h0033, 8'h00, 1'b0, 16'd1};
        vecs[7] = '{"halt",      8'h09, 32'hFF00_0000, 4'b0000, 1'b0, 16'hFE00, 16'h0000, 8'h09, 1'b1, 16'd0};
        vecs[8] = '{"ld_at20",   8'h20, 32'h1000_FFFF, 4'b0000, 1'b1, 16'h1000, 16'hFFFF, 8'h21, 1'b0, 16'd1};
        vecs[9] = '{"jmp_c5",    8'h40, 32'hF012_34C5, 4'b0000, 1'b0, 16'hFE00, 16'h0000, 8'hC5, 1'b0, 16'd0};

        // Reset state straight out of power-up.
        tick();
        reset = 1'b0;
        check_reset_outputs("por");

        // Table: reset, start, FETCH, EXEC, then check the EXEC outcome.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            rom[vecs[v].addr] = vecs[v].word;
            alu_flags = vecs[v].flags;
            pulse_start(vecs[v].addr);
            check({vecs[v].name, "_fetch_addr"}, 32'(rom_addr), 32'(vecs[v].addr));
            check({vecs[v].name, "_fetch_busy"}, 32'(busy), 32'h1);
            tick();
            check({vecs[v].name, "_exec_issue"}, 32'(issue_valid), 32'h0);
            tick();
            check({vecs[v].name, "_issue"}, 32'(issue_valid), 32'(vecs[v].exp_issue));
            check({vecs[v].name, "_operator"}, 32'(operator), 32'(vecs[v].exp_op));
            check({vecs[v].name, "_operand"}, 32'(operand), 32'(vecs[v].exp_opnd));
            check({vecs[v].name, "_pc"}, 32'(pc), 32'(vecs[v].exp_pc));
            check({vecs[v].name, "_halted"}, 32'(halted), 32'(vecs[v].exp_halt));
            check({vecs[v].name, "_count"}, 32'(instr_count), 32'(vecs[v].exp_cnt));
            tick();
            check({vecs[v].name, "_pulse_end"}, 32'(issue_valid), 32'h0);
            check({vecs[v].name, "_nop_operator"}, 32'(operator), 32'hFE00);
            rom[vecs[v].addr] = 32'hFF00_0000;
        end
        alu_flags = '0;

        // ADD, XOR, HALT: two issues two cycles apart, then HALT at pc 2.
        do_reset();
        rom[0] = 32'h0000_0001;
        rom[1] = 32'h0400_0002;
        rom[2] = 32'hFF00_0000;
        exp_q.push_back(32'h0000_0001);
        exp_q.push_back(32'h0400_0002);
        pulse_start(8'h00);
        issues     = 0;
        last_issue = 0;
        gap        = 0;
        done       = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            tick();
            if (issue_valid) begin
                if (exp_q.size() == 0) begin
                    check("prog_extra_issue", {operator, operand}, 32'hFFFF_FFFF);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("prog_issue_word", {operator, operand}, exp_word);
                end
                if (issues > 0) gap = c - last_issue;
                last_issue = c;
                issues++;
            end
            if (halted) done = 1'b1;
        end
        check("prog_reached_halt", 32'(done), 32'h1);
        check("prog_issue_count", 32'(issues), 32'd2);
        check("prog_issue_gap", 32'(gap), 32'd2);
        check("prog_pc", 32'(pc), 32'h2);
        check("prog_count", 32'(instr_count), 32'd2);
        check("prog_busy_off", 32'(busy), 32'h0);
        exp_q.delete();

        // HALT restart: start again from HALT clears the count and reloads pc.
        pulse_start(8'h20);
        check("restart_pc", 32'(pc), 32'h20);
        check("restart_count", 32'(instr_count), 32'h0);
        check("restart_halted", 32'(halted), 32'h0);
        check("restart_busy", 32'(busy), 32'h1);
        rom[8'h20] = 32'h1000_00AA;
        tick();
        tick();
        check("restart_issue", 32'(issue_valid), 32'h1);
        check("restart_operand", 32'(operand), 32'h00AA);
        check("restart_count1", 32'(instr_count), 32'd1);

        // JMP at 3 resumes fetching at address 0.
        do_reset();
        rom[3] = 32'hF000_0000;
        rom[0] = 32'h0101_0004;
        pulse_start(8'h03);
        tick();
        tick();
        check("jmp_no_issue", 32'(issue_valid), 32'h0);
        check("jmp_pc", 32'(pc), 32'h0);
        check("jmp_resume_addr", 32'(rom_addr), 32'h0);
        check("jmp_resume_state", 32'(dbg_state), 32'(S_FETCH));
        tick();
        tick();
        check("jmp_resume_issue", 32'(issue_valid), 32'h1);
        check("jmp_resume_word", {operator, operand}, 32'h0101_0004);

        // start while busy is ignored.
        do_reset();
        rom[5] = 32'h0200_0001;
        rom[6] = 32'h0300_0002;
        pulse_start(8'h05);
        start      = 1'b1;
        start_addr = 8'h80;
        tick();
        check("busy_start_fetch_pc", 32'(pc), 32'h05);
        tick();
        check("busy_start_exec_pc", 32'(pc), 32'h06);
        check("busy_start_count", 32'(instr_count), 32'd1);
        start = 1'b0;

        // Reset during EXEC with an issuing word on rom_data.
        tick();
        check("rst_exec_state", 32'(dbg_state), 32'(S_EXEC));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("rst_exec");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
